bin2bcd_seq: RTL

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It converts counter values, such as seconds-of-day or minutes, into packed BCD digits for the display and seven-segment path. It uses a start/done handshake and holds its last result. It reports overflow when DIGITS is too small for the input value.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bin2bcd_seq_add3.sv | 20 ++
 rtl/bin2bcd_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter.
//   BCD_DIGIT_W  - width of one packed BCD digit
//   ADD3_THRESH  - digits at or above this value get corrected before a shift
//   ADD3_OFFSET  - correction added to such digits
//   bcd_state_e  - converter FSM encoding
package bcd_pkg;

    localparam int          BCD_DIGIT_W = 4;
    localparam logic [3:0]  ADD3_THRESH = 4'd5;
    localparam logic [3:0]  ADD3_OFFSET = 4'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } bcd_state_e;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit-correction cell: a digit of 5..15 gets +3 (mod 16)
// so that the following left shift carries correctly into the next digit.
// Ports:
//   digit_i - scratch digit before correction
//   digit_o - corrected digit
module bin2bcd_seq_add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= ADD3_THRESH) begin
            digit_o = digit_i + ADD3_OFFSET;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock. A conversion accepted on edge T0 presents its result with a one-cycle
// done pulse in the cycle after edge T0+BIN_W. bcd/overflow hold between
// conversions and never show intermediate values.
// Valid/ready contract: start is taken on any rising edge where busy=0; bin is
// sampled on that same edge; start while busy=1 is dropped, nothing queues.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start, bin - conversion request and operand
//   busy       - conversion in progress (also the FSM state: 1 = SHIFT)
//   done       - one-cycle result strobe
//   bcd        - packed result, digit 0 in bits [3:0]
//   overflow   - operand did not fit in DIGITS decimal digits
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          overflow
);

    localparam int SCR_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    bcd_state_e         state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;

    logic [SCR_W-1:0]   scratch_corr;
    logic [SCR_W-1:0]   scratch_shift;
    logic               ovf_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bin2bcd_seq_add3 u_add3 (
            .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (scratch_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The bit leaving the top digit is a decimal carry beyond DIGITS digits.
    assign scratch_shift = {scratch_corr[SCR_W-2:0], shift_q[BIN_W-1]};
    assign ovf_next      = ovf_acc_q | scratch_corr[SCR_W-1];

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        ovf_acc_d  = ovf_acc_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin;
                    scratch_d = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = scratch_shift;
                shift_d   = shift_q << 1;
                ovf_acc_d = ovf_next;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    bcd_d      = scratch_shift;
                    overflow_d = ovf_next;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            ovf_acc_q  <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            ovf_acc_q  <= ovf_acc_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule
